// File: rtl/expr_eval_if.sv
// Character-stream bus for expr_eval: the source drives in/in_valid, the evaluator
// returns out/value/ovf. A character is transferred on any rising edge with in_valid=1.
interface expr_eval_if #(
    parameter int W = 32
);
    logic [7:0]   in;
    logic         in_valid;
    logic         out;
    logic [W-1:0] value;
    logic         ovf;

    modport master (output in, output in_valid, input out, input value, input ovf);
    modport slave  (input in, input in_valid, output out, output value, output ovf);
endinterface

// File: rtl/expr_eval.sv
// Evaluates "d(+|*)d..." single-digit expressions on an ASCII stream, '*' before '+'.
// Define EXPR_OVF_EN to build the sticky wrap-around detector driving ovf.
module expr_eval #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       clr,
    expr_eval_if.slave bus,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        NUM     = 3'd1,
        OP_ADD  = 3'd2,
        OP_MUL  = 3'd3,
        INVALID = 3'd4
    } state_t;

    state_t       state;
    logic [W-1:0] sum;
    logic [W-1:0] term;
    logic         is_digit;
    logic [3:0]   d;

    assign is_digit  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    // For '0'..'9' the low nibble of the ASCII code is the digit itself.
    assign d         = bus.in[3:0];
    assign state_dbg = state;

`ifdef EXPR_OVF_EN
    // Widened results: bit W (or bits W+3:W) carry the overflow information.
    logic [W:0]   add_st;
    logic [W+3:0] mul_t;
    logic [W:0]   fin_add;
    logic [W:0]   fin_mul;
    assign add_st  = {1'b0, sum} + {1'b0, term};
    assign mul_t   = {4'b0, term} * {{W{1'b0}}, d};
    assign fin_add = {1'b0, sum} + {{(W-3){1'b0}}, d};
    assign fin_mul = {1'b0, sum} + {1'b0, mul_t[W-1:0]};
`else
    logic [W-1:0] add_st;
    logic [W-1:0] mul_t;
    logic [W-1:0] fin_add;
    logic [W-1:0] fin_mul;
    assign add_st  = sum + term;
    assign mul_t   = term * W'(d);
    assign fin_add = sum + W'(d);
    assign fin_mul = sum + mul_t;
    assign bus.ovf = 1'b0;
`endif

    // out/value are registered alongside the state so they change only on a consumed character.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= EMPTY;
            sum       <= '0;
            term      <= '0;
            bus.out   <= 1'b0;
            bus.value <= '0;
`ifdef EXPR_OVF_EN
            bus.ovf   <= 1'b0;
`endif
        end else if (bus.in_valid) begin
            bus.out   <= 1'b0;
            bus.value <= '0;
            case (state)
                EMPTY: begin
                    if (is_digit) begin
                        state     <= NUM;
                        sum       <= '0;
                        term      <= W'(d);
                        bus.out   <= 1'b1;
                        bus.value <= W'(d);
                    end else begin
                        state <= INVALID;
                    end
                end
                NUM: begin
                    if (bus.in == 8'h2B) begin
                        state <= OP_ADD;
                        sum   <= add_st[W-1:0];
`ifdef EXPR_OVF_EN
                        if (add_st[W]) bus.ovf <= 1'b1;
`endif
                    end else if (bus.in == 8'h2A) begin
                        state <= OP_MUL;
                    end else begin
                        state <= INVALID;
                    end
                end
                OP_ADD: begin
                    if (is_digit) begin
                        state     <= NUM;
                        term      <= W'(d);
                        bus.out   <= 1'b1;
                        bus.value <= fin_add[W-1:0];
`ifdef EXPR_OVF_EN
                        if (fin_add[W]) bus.ovf <= 1'b1;
`endif
                    end else begin
                        state <= INVALID;
                    end
                end
                OP_MUL: begin
                    if (is_digit) begin
                        state     <= NUM;
                        term      <= mul_t[W-1:0];
                        bus.out   <= 1'b1;
                        bus.value <= fin_mul[W-1:0];
`ifdef EXPR_OVF_EN
                        if ((|mul_t[W+3:W]) || fin_mul[W]) bus.ovf <= 1'b1;
`endif
                    end else begin
                        state <= INVALID;
                    end
                end
                default: state <= INVALID;
            endcase
        end
    end
endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a 32-bit and an 8-bit instance share one character stream.
module tb_expr_eval;
    localparam logic [2:0] S_EMPTY   = 3'd0;
    localparam logic [2:0] S_INVALID = 3'd4;
`ifdef EXPR_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [2:0] st32, st8;
    int         n_checks = 0;
    int         n_fail   = 0;

    expr_eval_if #(.W(32)) if32 ();
    expr_eval_if #(.W(8))  if8 ();

    expr_eval #(.W(32)) dut32 (.clk(clk), .clr(clr), .bus(if32.slave), .state_dbg(st32));
    expr_eval #(.W(8))  dut8  (.clk(clk), .clr(clr), .bus(if8.slave),  .state_dbg(st8));

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        if32.in = c; if32.in_valid = 1'b1;
        if8.in  = c; if8.in_valid  = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0; if8.in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        if32.in_valid = 1'b0; if8.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_clr(input logic v, input logic [7:0] c);
        @(negedge clk);
        clr = 1'b1;
        if32.in = c; if32.in_valid = v;
        if8.in  = c; if8.in_valid  = v;
        @(posedge clk); #1;
        clr = 1'b0;
        if32.in_valid = 1'b0; if8.in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        n_checks++;
        if (if32.out !== 1'b0 || if32.value !== 32'd0 || if32.ovf !== 1'b0 || st32 !== S_EMPTY) begin
            n_fail++;
            $display("FAIL reset32 got out=%0b value=%0d ovf=%0b st=%0d exp 0 0 0 %0d", if32.out, if32.value, if32.ovf, st32, S_EMPTY);
        end
        n_checks++;
        if (if8.out !== 1'b0 || if8.value !== 8'd0 || if8.ovf !== 1'b0 || st8 !== S_EMPTY) begin
            n_fail++;
            $display("FAIL reset8 got out=%0b value=%0d ovf=%0b st=%0d exp 0 0 0 %0d", if8.out, if8.value, if8.ovf, st8, S_EMPTY);
        end
    endtask

    task automatic test_precedence();
        logic [7:0]  ch [5] = '{"1", "+", "2", "*", "3"};
        logic        eo [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ev [5] = '{32'd1, 32'd0, 32'd3, 32'd0, 32'd7};
        do_clr(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            send(ch[i]);
            n_checks++;
            if (if32.out !== eo[i] || if32.value !== ev[i]) begin
                n_fail++;
                $display("FAIL prec[%0d] got out=%0b value=%0d exp out=%0b value=%0d", i, if32.out, if32.value, eo[i], ev[i]);
            end
        end
        n_checks++;
        if (if32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL prec_ovf got %0b exp 0", if32.ovf);
        end
    endtask

    task automatic test_gap();
        logic [7:0]  ch [10] = '{"2", "*", 8'h00, 8'h00, 8'h00, "3", "+", "4", "*", "5"};
        logic        vl [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        eo [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ev [10] = '{32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd6, 32'd0, 32'd10, 32'd0, 32'd26};
        do_clr(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (vl[i]) send(ch[i]);
            else idle();
            n_checks++;
            if (if32.out !== eo[i] || if32.value !== ev[i]) begin
                n_fail++;
                $display("FAIL gap[%0d] got out=%0b value=%0d exp out=%0b value=%0d", i, if32.out, if32.value, eo[i], ev[i]);
            end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] ch [7] = '{"1", "2", "3", "4", "5", "6", "7"};
        do_clr(1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            send(ch[i]);
            n_checks++;
            if (if32.out !== (i == 0) || if32.value !== ((i == 0) ? 32'd1 : 32'd0)) begin
                n_fail++;
                $display("FAIL multidigit[%0d] got out=%0b value=%0d exp out=%0b", i, if32.out, if32.value, (i == 0));
            end
        end
        n_checks++;
        if (st32 !== S_INVALID) begin
            n_fail++;
            $display("FAIL multidigit_state got %0d exp %0d", st32, S_INVALID);
        end
        do_clr(1'b0, 8'h00);
        send("+");
        n_checks++;
        if (if32.out !== 1'b0 || st32 !== S_INVALID) begin
            n_fail++;
            $display("FAIL lead_op got out=%0b st=%0d exp 0 %0d", if32.out, st32, S_INVALID);
        end
        send("1");
        n_checks++;
        if (if32.out !== 1'b0 || if32.value !== 32'd0) begin
            n_fail++;
            $display("FAIL lead_op_digit got out=%0b value=%0d exp 0 0", if32.out, if32.value);
        end
    endtask

    task automatic test_mul_wrap();
        do_clr(1'b0, 8'h00);
        send("9"); send("*"); send("9");
        n_checks++;
        if (if8.value !== 8'd81 || if8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_mid got value=%0d ovf=%0b exp 81 0", if8.value, if8.ovf);
        end
        send("*"); send("9");
        n_checks++;
        if (if8.out !== 1'b1 || if8.value !== 8'd217 || if8.ovf !== OVF_ON) begin
            n_fail++;
            $display("FAIL wrap8 got out=%0b value=%0d ovf=%0b exp 1 217 %0b", if8.out, if8.value, if8.ovf, OVF_ON);
        end
        n_checks++;
        if (if32.out !== 1'b1 || if32.value !== 32'd729 || if32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap32 got out=%0b value=%0d ovf=%0b exp 1 729 0", if32.out, if32.value, if32.ovf);
        end
        do_clr(1'b0, 8'h00);
        n_checks++;
        if (if8.out !== 1'b0 || if8.value !== 8'd0 || if8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_clr got out=%0b value=%0d ovf=%0b exp 0 0 0", if8.out, if8.value, if8.ovf);
        end
    endtask

    task automatic test_clr_priority();
        do_clr(1'b0, 8'h00);
        send("5"); send("+");
        do_clr(1'b1, "7");
        n_checks++;
        if (if32.out !== 1'b0 || if32.value !== 32'd0 || st32 !== S_EMPTY) begin
            n_fail++;
            $display("FAIL clr_prio got out=%0b value=%0d st=%0d exp 0 0 %0d", if32.out, if32.value, st32, S_EMPTY);
        end
        send("7");
        n_checks++;
        if (if32.out !== 1'b1 || if32.value !== 32'd7) begin
            n_fail++;
            $display("FAIL clr_sum got out=%0b value=%0d exp 1 7", if32.out, if32.value);
        end
    endtask

    task automatic test_final_add_ovf();
        logic [7:0] ch [8] = '{"9", "*", "9", "*", "3", "+", "9", "*"};
        do_clr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) send(ch[i]);
        n_checks++;
        if (if8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL final_pre got ovf=%0b exp 0", if8.ovf);
        end
        send("9");
        n_checks++;
        if (if8.out !== 1'b1 || if8.value !== 8'd68 || if8.ovf !== OVF_ON) begin
            n_fail++;
            $display("FAIL final8 got out=%0b value=%0d ovf=%0b exp 1 68 %0b", if8.out, if8.value, if8.ovf, OVF_ON);
        end
        n_checks++;
        if (if32.value !== 32'd324 || if32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL final32 got value=%0d ovf=%0b exp 324 0", if32.value, if32.ovf);
        end
    endtask

    task automatic test_char_bounds();
        logic [7:0] bad [3] = '{8'h2F, 8'h3A, 8'h80};
        do_clr(1'b0, 8'h00);
        send("0"); send("+"); send("9");
        n_checks++;
        if (if32.out !== 1'b1 || if32.value !== 32'd9) begin
            n_fail++;
            $display("FAIL digit_edges got out=%0b value=%0d exp 1 9", if32.out, if32.value);
        end
        for (int i = 0; i < 3; i++) begin
            do_clr(1'b0, 8'h00);
            send(bad[i]);
            n_checks++;
            if (if32.out !== 1'b0 || st32 !== S_INVALID) begin
                n_fail++;
                $display("FAIL nondigit[%0h] got out=%0b st=%0d exp 0 %0d", bad[i], if32.out, st32, S_INVALID);
            end
        end
    endtask

    initial begin
        if32.in = 8'h00; if32.in_valid = 1'b0;
        if8.in  = 8'h00; if8.in_valid  = 1'b0;
        test_reset();
        test_precedence();
        test_gap();
        test_invalid();
        test_mul_wrap();
        test_clr_priority();
        test_final_add_ovf();
        test_char_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Evaluation stage sitting downstream of the expression-string recognizer, on the same 8-bit ASCII character stream.
- Tracks the same grammar: single decimal digits separated by '+' or '*'.
- Also computes the arithmetic value of the prefix received so far, with '*' binding tighter than '+'.
- Presents the result together with a valid flag; the flag matches the recognizer's accept output.

Parameters:
- W, 32, width of the result datapath in bits; all arithmetic is modulo 2^W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- in  in  8  ASCII character.
- in_valid  in  1  character strobe; in is consumed only on a rising edge with in_valid=1.
- out  out  1  1 when the accepted prefix is a complete valid expression.
- value  out  W  value of the expression when out=1; 0 when out=0.
- ovf  out  1  sticky: some operation wrapped modulo 2^W since the last clr; tied 0 without EXPR_OVF_EN.

Behaviour:
- State register: EMPTY, NUM, OP_ADD, OP_MUL, INVALID.
- Internal registers:
  - sum (W): total of completed additive terms.
  - term (W): current product term.
- Digit value d = in - "0" (0..9). "Digit" means "0" <= in <= "9".
- Reset (clr=1 at a rising edge): state=EMPTY, sum=0, term=0, ovf=0, hence out=0 and value=0.
  - clr has priority over in_valid in the same cycle.
  - clr is effective from any state, including mid-expression and INVALID.
- in_valid=0: all state and registers hold. Gaps of any length are transparent.
- Transitions on an accepted character:
  - EMPTY + digit -> NUM; sum=0, term=d.
  - EMPTY + other -> INVALID.
  - NUM + '+' -> OP_ADD; sum=sum+term.
  - NUM + '*' -> OP_MUL; sum and term unchanged.
  - NUM + digit or other -> INVALID. Multi-digit numbers are illegal.
  - OP_ADD + digit -> NUM; term=d.
  - OP_MUL + digit -> NUM; term=term*d, truncated to W bits.
  - OP_ADD/OP_MUL + non-digit -> INVALID.
  - INVALID + anything -> INVALID, until clr. sum and term freeze on entry to INVALID.
- Outputs:
  - out = (state==NUM). It is a registered state decode with no combinational path from in.
  - value = (state==NUM) ? sum+term (mod 2^W) : 0.
- Latency: out/value reflect a character starting the cycle after the edge that consumes it. This is the same timing as the recognizer, so the two blocks' out signals are cycle-identical on a shared stream.
- Multiply is W x 4 bits; single-cycle combinational, registered into term.
- Non-ASCII bytes (>= 8'h80) count as "other".

Optional Feature:
- Macro: EXPR_OVF_EN.
- Defined:
  - Addition is computed at W+1 bits; a carry out sets ovf.
  - Multiplication is computed at W+4 bits; any nonzero upper 4 bits set ovf.
  - The final sum+term output addition is also checked: if its carry would be set while state==NUM, ovf is set on that edge.
  - ovf is sticky until clr, and is unaffected by entry to INVALID.
  - Results still wrap modulo 2^W.
- Not defined: no overflow logic is synthesized and ovf is constant 0.

Test Plan:
- W=32, stream "1","+","2","*","3" on consecutive cycles -> out sequence 1,0,1,0,1; value sequence 1,0,3,0,7; ovf=0.
- Stream "2","*","3","+","4","*","5" with in_valid low for 3 cycles between "*" and "3" -> out and value hold during the gap; final value=26 and out=1.
- Stream "1","2" -> out=1 then 0 and stays 0 for 5 further digits. Separately, "+","1" from reset -> INVALID after the first character and out never rises.
- W=8 with EXPR_OVF_EN, stream "9","*","9","*","9" -> final value=217 (729 mod 256), out=1, ovf=1. Then clr -> out=0, value=0, ovf=0. Without the macro -> value=217, ovf=0.
- Stream "5","+" then clr asserted together with in_valid=1, in="7" -> next cycle state EMPTY, out=0. Then "7" -> out=1, value=7, showing sum was cleared.
- W=8 with EXPR_OVF_EN, stream "9","*","9","*","3","+","9","*","9" -> final value=68, ovf=1 set at the last edge by the sum+term output addition.
